// File: rtl/vram_port_arbiter_if.sv
// vram_port_arbiter_if
//   Bundles every bus signal of the VRAM port arbiter so the arbiter and
//   its environment connect through one port.
//   Port groups:
//     cpu_*        6502-side strobe request, read return and busy flag
//     vid_*        VDU character-fetch valid/ack request and read return
//     mem_*        the single shared block-RAM port (registered outputs, mem_q back)
//     conflict_cnt saturating count of contended edges
//   Modports:
//     slave  - the arbiter
//     master - the requesters plus the RAM (environment side)
interface vram_port_arbiter_if #(
  parameter int ADDR_W = 15
) ();
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_busy;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [7:0]        vid_rdata;
  logic              vid_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rden;
  logic              mem_wren;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_q;

  logic [15:0]       conflict_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_rvalid, cpu_busy,
    input  vid_req, vid_addr,
    output vid_ack, vid_rdata, vid_rvalid,
    output mem_addr, mem_rden, mem_wren, mem_wdata,
    input  mem_q,
    output conflict_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_rvalid, cpu_busy,
    output vid_req, vid_addr,
    input  vid_ack, vid_rdata, vid_rvalid,
    input  mem_addr, mem_rden, mem_wren, mem_wdata,
    output mem_q,
    input  conflict_cnt
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter
//   Shares one read/write block-RAM port between the 6502 bus (single-cycle
//   strobes) and the VDU character fetcher (valid/ack). The CPU has priority,
//   but video takes the port once it has been refused VID_MAX_WAIT times in a
//   row. A CPU strobe that loses is parked in a one-entry buffer and issued on
//   the very next cycle. Read data is steered back to its owner by a two-stage
//   tag pipeline matching the RAM's one-cycle read latency.
//   Ports:
//     fst_clk - system clock, rising edge
//     rst     - asynchronous active-high reset
//     bus     - vram_port_arbiter_if.slave (CPU, video, RAM and counter signals)
module vram_port_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int VID_MAX_WAIT = 4
) (
  input logic                fst_clk,
  input logic                rst,
  vram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_VID  = 2'd2
  } tag_e;

  localparam logic [7:0] WAIT_MAX = 8'(VID_MAX_WAIT);

  logic              pend_valid_q, pend_valid_d;
  logic              pend_we_q, pend_we_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]        pend_wdata_q, pend_wdata_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rden_q, mem_rden_d;
  logic              mem_wren_q, mem_wren_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  tag_e              tag0_q, tag0_d;
  tag_e              tag1_q, tag1_d;

  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic [7:0]        vid_rdata_q, vid_rdata_d;
  logic              vid_rvalid_q, vid_rvalid_d;

  logic [7:0]        vid_wait_q, vid_wait_d;
  logic [15:0]       conflict_cnt_q, conflict_cnt_d;

  logic              starve;
  logic              sel_pend, sel_vid, sel_cpu;

  always_comb begin
    starve   = (vid_wait_q == WAIT_MAX);
    sel_pend = 1'b0;
    sel_vid  = 1'b0;
    sel_cpu  = 1'b0;
    if (pend_valid_q)                 sel_pend = 1'b1;
    else if (bus.vid_req && starve)   sel_vid  = 1'b1;
    else if (bus.cpu_req)             sel_cpu  = 1'b1;
    else if (bus.vid_req)             sel_vid  = 1'b1;

    // A strobe that is not the direct winner must be parked. Because a parked
    // request always wins the next cycle, one entry is enough.
    pend_valid_d = bus.cpu_req && !sel_cpu;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    if (pend_valid_d) begin
      pend_we_d    = bus.cpu_we;
      pend_addr_d  = bus.cpu_addr;
      pend_wdata_d = bus.cpu_wdata;
    end

    // Idle cycles keep address/data so the RAM inputs stay quiet.
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rden_d  = 1'b0;
    mem_wren_d  = 1'b0;
    tag0_d      = TAG_NONE;
    if (sel_pend) begin
      mem_addr_d  = pend_addr_q;
      mem_wdata_d = pend_wdata_q;
      mem_wren_d  = pend_we_q;
      mem_rden_d  = !pend_we_q;
      tag0_d      = pend_we_q ? TAG_NONE : TAG_CPU;
    end else if (sel_cpu) begin
      mem_addr_d  = bus.cpu_addr;
      mem_wdata_d = bus.cpu_wdata;
      mem_wren_d  = bus.cpu_we;
      mem_rden_d  = !bus.cpu_we;
      tag0_d      = bus.cpu_we ? TAG_NONE : TAG_CPU;
    end else if (sel_vid) begin
      mem_addr_d  = bus.vid_addr;
      mem_rden_d  = 1'b1;
      tag0_d      = TAG_VID;
    end

    // tag1 lines up with mem_q: data sampled at the edge where tag1 names an owner.
    tag1_d       = tag0_q;
    cpu_rvalid_d = (tag1_q == TAG_CPU);
    vid_rvalid_d = (tag1_q == TAG_VID);
    cpu_rdata_d  = cpu_rvalid_d ? bus.mem_q : cpu_rdata_q;
    vid_rdata_d  = vid_rvalid_d ? bus.mem_q : vid_rdata_q;

    if (bus.vid_req && !sel_vid)
      vid_wait_d = starve ? vid_wait_q : vid_wait_q + 8'd1;
    else
      vid_wait_d = 8'd0;

    conflict_cnt_d = conflict_cnt_q;
    if ((bus.cpu_req || pend_valid_q) && bus.vid_req && (conflict_cnt_q != 16'hFFFF))
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge fst_clk or posedge rst) begin
    if (rst) begin
      pend_valid_q   <= 1'b0;
      pend_we_q      <= 1'b0;
      pend_addr_q    <= '0;
      pend_wdata_q   <= 8'd0;
      mem_addr_q     <= '0;
      mem_rden_q     <= 1'b0;
      mem_wren_q     <= 1'b0;
      mem_wdata_q    <= 8'd0;
      tag0_q         <= TAG_NONE;
      tag1_q         <= TAG_NONE;
      cpu_rdata_q    <= 8'd0;
      cpu_rvalid_q   <= 1'b0;
      vid_rdata_q    <= 8'd0;
      vid_rvalid_q   <= 1'b0;
      vid_wait_q     <= 8'd0;
      conflict_cnt_q <= 16'd0;
    end else begin
      pend_valid_q   <= pend_valid_d;
      pend_we_q      <= pend_we_d;
      pend_addr_q    <= pend_addr_d;
      pend_wdata_q   <= pend_wdata_d;
      mem_addr_q     <= mem_addr_d;
      mem_rden_q     <= mem_rden_d;
      mem_wren_q     <= mem_wren_d;
      mem_wdata_q    <= mem_wdata_d;
      tag0_q         <= tag0_d;
      tag1_q         <= tag1_d;
      cpu_rdata_q    <= cpu_rdata_d;
      cpu_rvalid_q   <= cpu_rvalid_d;
      vid_rdata_q    <= vid_rdata_d;
      vid_rvalid_q   <= vid_rvalid_d;
      vid_wait_q     <= vid_wait_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign bus.vid_ack      = sel_vid;
  assign bus.cpu_busy     = pend_valid_q;
  assign bus.cpu_rdata    = cpu_rdata_q;
  assign bus.cpu_rvalid   = cpu_rvalid_q;
  assign bus.vid_rdata    = vid_rdata_q;
  assign bus.vid_rvalid   = vid_rvalid_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_rden     = mem_rden_q;
  assign bus.mem_wren     = mem_wren_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
module tb_vram_port_arbiter;

  logic fst_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 fst_clk = ~fst_clk;

  vram_port_arbiter_if #(.ADDR_W(15)) bus ();

  vram_port_arbiter #(.ADDR_W(15), .VID_MAX_WAIT(4)) dut (
    .fst_clk (fst_clk),
    .rst     (rst),
    .bus     (bus)
  );

  // RAM model: one-cycle registered read; unwritten words read addr[7:0]^A5.
  bit [7:0] ram     [0:32767];
  bit       written [0:32767];
  always @(posedge fst_clk) begin
    if (bus.mem_wren) begin
      ram[bus.mem_addr]     <= bus.mem_wdata;
      written[bus.mem_addr] <= 1'b1;
    end
    if (bus.mem_rden)
      bus.mem_q <= written[bus.mem_addr] ? ram[bus.mem_addr] : (bus.mem_addr[7:0] ^ 8'hA5);
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic step();
    @(posedge fst_clk);
    #1;
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [14:0] caddr,
                       input logic [7:0] cwd, input logic vreq, input logic [14:0] vaddr);
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.vid_req   = vreq;
    bus.vid_addr  = vaddr;
  endtask

  typedef struct {
    logic        creq, cwe;
    logic [14:0] caddr;
    logic [7:0]  cwd;
    logic        vreq;
    logic [14:0] vaddr;
    logic        e_ack, e_rden, e_wren;
    logic [14:0] e_addr;
    logic [7:0]  e_wd;
    logic        e_busy;
    logic        e_crv;
    logic [7:0]  e_crd;
    logic        e_vrv;
    logic [7:0]  e_vrd;
    logic [15:0] e_conf;
  } vec_t;

  function automatic vec_t mk(
      input logic creq, input logic cwe, input logic [14:0] caddr, input logic [7:0] cwd,
      input logic vreq, input logic [14:0] vaddr,
      input logic ack, input logic rden, input logic wren, input logic [14:0] addr,
      input logic [7:0] wd, input logic busy, input logic crv, input logic [7:0] crd,
      input logic vrv, input logic [7:0] vrd, input logic [15:0] conf);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.vreq = vreq; v.vaddr = vaddr;
    v.e_ack = ack; v.e_rden = rden; v.e_wren = wren; v.e_addr = addr; v.e_wd = wd;
    v.e_busy = busy; v.e_crv = crv; v.e_crd = crd; v.e_vrv = vrv; v.e_vrd = vrd;
    v.e_conf = conf;
    return v;
  endfunction

  localparam int NV = 24;
  vec_t vecs [NV];

  initial begin
    //               creq we caddr   wd    vreq vaddr   ack rd wr addr    wd    busy crv crd   vrv vrd   conf
    vecs[0]  = mk(1, 1, 15'h2222, 8'h44, 0, 15'h0000, 0, 0, 1, 15'h2222, 8'h44, 0, 0, 8'h00, 0, 8'h00, 0);
    vecs[1]  = mk(1, 0, 15'h2222, 8'h00, 0, 15'h0000, 0, 1, 0, 15'h2222, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
    vecs[2]  = mk(0, 0, 15'h0000, 8'h00, 0, 15'h0000, 0, 0, 0, 15'h0000, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
    vecs[3]  = mk(0, 0, 15'h0000, 8'h00, 0, 15'h0000, 0, 0, 0, 15'h0000, 8'h00, 0, 1, 8'h44, 0, 8'h00, 0);
    vecs[4]  = mk(0, 0, 15'h0000, 8'h00, 1, 15'h2000, 1, 1, 0, 15'h2000, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
    vecs[5]  = mk(0, 0, 15'h0000, 8'h00, 1, 15'h2001, 1, 1, 0, 15'h2001, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
    vecs[6]  = mk(0, 0, 15'h0000, 8'h00, 1, 15'h2002, 1, 1, 0, 15'h2002, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0);
    vecs[7]  = mk(0, 0, 15'h0000, 8'h00, 1, 15'h2003, 1, 1, 0, 15'h2003, 8'h00, 0, 0, 8'h00, 1, 8'hA4, 0);
    vecs[8]  = mk(0, 0, 15'h0000, 8'h00, 0, 15'h0000, 0, 0, 0, 15'h0000, 8'h00, 0, 0, 8'h00, 1, 8'hA7, 0);
    vecs[9]  = mk(0, 0, 15'h0000, 8'h00, 0, 15'h0000, 0, 0, 0, 15'h0000, 8'h00, 0, 0, 8'h00, 1, 8'hA6, 0);
    vecs[10] = mk(1, 0, 15'h1234, 8'h00, 1, 15'h3000, 0, 1, 0, 15'h1234, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1);
    vecs[11] = mk(0, 0, 15'h0000, 8'h00, 1, 15'h3000, 1, 1, 0, 15'h3000, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1);
    vecs[12] = mk(0, 0, 15'h0000, 8'h00, 0, 15'h0000, 0, 0, 0, 15'h0000, 8'h00, 0, 1, 8'h91, 0, 8'h00, 1);
    vecs[13] = mk(0, 0, 15'h0000, 8'h00, 0, 15'h0000, 0, 0, 0, 15'h0000, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 1);
    vecs[14] = mk(1, 0, 15'h0100, 8'h00, 1, 15'h4000, 0, 1, 0, 15'h0100, 8'h00, 0, 0, 8'h00, 0, 8'h00, 2);
    vecs[15] = mk(1, 0, 15'h0101, 8'h00, 1, 15'h4000, 0, 1, 0, 15'h0101, 8'h00, 0, 0, 8'h00, 0, 8'h00, 3);
    vecs[16] = mk(1, 0, 15'h0102, 8'h00, 1, 15'h4000, 0, 1, 0, 15'h0102, 8'h00, 0, 1, 8'hA5, 0, 8'h00, 4);
    vecs[17] = mk(1, 0, 15'h0103, 8'h00, 1, 15'h4000, 0, 1, 0, 15'h0103, 8'h00, 0, 1, 8'hA4, 0, 8'h00, 5);
    vecs[18] = mk(1, 0, 15'h0104, 8'h00, 1, 15'h4000, 1, 1, 0, 15'h4000, 8'h00, 1, 1, 8'hA7, 0, 8'h00, 6);
    vecs[19] = mk(1, 0, 15'h0105, 8'h00, 1, 15'h4000, 0, 1, 0, 15'h0104, 8'h00, 1, 1, 8'hA6, 0, 8'h00, 7);
    vecs[20] = mk(0, 0, 15'h0000, 8'h00, 1, 15'h4000, 0, 1, 0, 15'h0105, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 8);
    vecs[21] = mk(0, 0, 15'h0000, 8'h00, 1, 15'h4000, 1, 1, 0, 15'h4000, 8'h00, 0, 1, 8'hA1, 0, 8'h00, 8);
    vecs[22] = mk(0, 0, 15'h0000, 8'h00, 0, 15'h0000, 0, 0, 0, 15'h0000, 8'h00, 0, 1, 8'hA0, 0, 8'h00, 8);
    vecs[23] = mk(0, 0, 15'h0000, 8'h00, 0, 15'h0000, 0, 0, 0, 15'h0000, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 8);

    // Reset state
    drive(0, 0, 15'h0, 8'h0, 0, 15'h0);
    step();
    step();
    chk("reset_mem_rden", 0, 32'(bus.mem_rden), 0);
    chk("reset_cpu_busy", 0, 32'(bus.cpu_busy), 0);
    chk("reset_conflict", 0, 32'(bus.conflict_cnt), 0);
    chk("reset_cpu_rdata", 0, 32'(bus.cpu_rdata), 0);
    rst = 1'b0;

    // Table: inputs for cycle i, combinational ack before the edge, registered results after it
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd, vecs[i].vreq, vecs[i].vaddr);
      #1;
      chk("vid_ack", i, 32'(bus.vid_ack), 32'(vecs[i].e_ack));
      step();
      chk("mem_rden", i, 32'(bus.mem_rden), 32'(vecs[i].e_rden));
      chk("mem_wren", i, 32'(bus.mem_wren), 32'(vecs[i].e_wren));
      if (vecs[i].e_rden || vecs[i].e_wren)
        chk("mem_addr", i, 32'(bus.mem_addr), 32'(vecs[i].e_addr));
      if (vecs[i].e_wren)
        chk("mem_wdata", i, 32'(bus.mem_wdata), 32'(vecs[i].e_wd));
      chk("cpu_busy", i, 32'(bus.cpu_busy), 32'(vecs[i].e_busy));
      chk("cpu_rvalid", i, 32'(bus.cpu_rvalid), 32'(vecs[i].e_crv));
      if (vecs[i].e_crv)
        chk("cpu_rdata", i, 32'(bus.cpu_rdata), 32'(vecs[i].e_crd));
      chk("vid_rvalid", i, 32'(bus.vid_rvalid), 32'(vecs[i].e_vrv));
      if (vecs[i].e_vrv)
        chk("vid_rdata", i, 32'(bus.vid_rdata), 32'(vecs[i].e_vrd));
      chk("conflict_cnt", i, 32'(bus.conflict_cnt), 32'(vecs[i].e_conf));
    end

    // Reset mid-operation: build up starvation so a CPU strobe gets parked
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 15'(32'h0200 + i), 8'h00, 1, 15'h5000);
      step();
    end
    drive(1, 0, 15'h0204, 8'h00, 1, 15'h5000);
    step();
    chk("pre_rst_busy", 0, 32'(bus.cpu_busy), 1);
    rst = 1'b1;
    drive(0, 0, 15'h0, 8'h0, 0, 15'h0);
    #1;
    chk("rst_cpu_busy", 0, 32'(bus.cpu_busy), 0);
    chk("rst_mem_rden", 0, 32'(bus.mem_rden), 0);
    chk("rst_mem_wren", 0, 32'(bus.mem_wren), 0);
    chk("rst_mem_addr", 0, 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 0, 32'(bus.mem_wdata), 0);
    chk("rst_cpu_rdata", 0, 32'(bus.cpu_rdata), 0);
    chk("rst_vid_rdata", 0, 32'(bus.vid_rdata), 0);
    chk("rst_rvalids", 0, 32'({bus.cpu_rvalid, bus.vid_rvalid}), 0);
    chk("rst_conflict", 0, 32'(bus.conflict_cnt), 0);
    chk("rst_vid_ack", 0, 32'(bus.vid_ack), 0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_no_rvalid", i, 32'({bus.cpu_rvalid, bus.vid_rvalid, bus.mem_rden}), 0);
    end

    // Saturation of the conflict counter
    drive(1, 0, 15'h0010, 8'h00, 1, 15'h6000);
    repeat (65534) step();
    chk("conflict_fffe", 0, 32'(bus.conflict_cnt), 32'hFFFE);
    step();
    chk("conflict_ffff", 0, 32'(bus.conflict_cnt), 32'hFFFF);
    repeat (4465) step();
    chk("conflict_sat", 0, 32'(bus.conflict_cnt), 32'hFFFF);
    drive(0, 0, 15'h0, 8'h0, 0, 15'h0);
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
